// File: rtl/mp_adc_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : mp_adc_seq_if
// Description : Command, operand-stream, result-stream and status bundle for
//               the multi-precision add/subtract sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface mp_adc_seq_if #(
    parameter int W    = 32,
    parameter int NW_W = 4
);
    // Command
    logic            start;
    logic            op_sub;
    logic [NW_W-1:0] nwords;
    // Operand stream
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    a_word;
    logic [W-1:0]    b_word;
    // Result stream
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_word;
    logic            out_last;
    // Status
    logic            busy;
    logic            done;
    logic            carry_out;
    logic            zero;
    logic            ovf;

    // Operand fetch / result writeback side
    modport master (
        output start, op_sub, nwords, in_valid, a_word, b_word, out_ready,
        input  in_ready, out_valid, out_word, out_last,
               busy, done, carry_out, zero, ovf
    );

    // Sequencer side
    modport slave (
        input  start, op_sub, nwords, in_valid, a_word, b_word, out_ready,
        output in_ready, out_valid, out_word, out_last,
               busy, done, carry_out, zero, ovf
    );
endinterface
`default_nettype wire

// File: rtl/mp_adc_seq.sv
`default_nettype none
// ============================================================================
// Module      : mp_adc_seq
// Description : Multi-precision add/subtract sequencer. Streams operand word
//               pairs LS word first through one W-bit add-with-carry datapath,
//               chains the carry between words and reports final carry, zero
//               and signed-overflow flags with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mp_adc_seq #(
    parameter int W    = 32,
    parameter int MAXW = 8,
    parameter int NW_W = 4
) (
    input wire          clk,
    input wire          rst_n,
    mp_adc_seq_if.slave bus
);

    localparam logic [NW_W-1:0] c_maxw = NW_W'(MAXW);
    localparam logic [NW_W-1:0] c_one  = NW_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic            r_op_sub;
    logic [NW_W-1:0] r_nwords;
    logic [NW_W-1:0] r_count;
    logic            r_carry;
    logic            r_zero_acc;
    logic            r_ovf_acc;

    logic [W-1:0]    r_out_word;
    logic            r_out_valid;
    logic            r_out_last;

    logic            r_carry_out;
    logic            r_zero;
    logic            r_ovf;

    logic            w_busy;
    logic            w_done;
    logic            w_start_ok;
    logic            w_in_ready;
    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_last_word;
    logic [W-1:0]    w_b_eff;
    logic [W:0]      w_sum;
    logic            w_msb_cin;

    // Only lengths 1..MAXW form a legal command; anything else is dropped.
    assign w_start_ok = bus.start && (bus.nwords != '0) && (bus.nwords <= c_maxw);

    // Accept input while words remain and the output stage can take a result
    // this cycle (empty, or draining in the same cycle).
    assign w_in_ready  = (r_state == S_RUN) && (r_count < r_nwords) &&
                         (!r_out_valid || bus.out_ready);
    assign w_in_fire   = w_in_ready && bus.in_valid;
    assign w_out_fire  = r_out_valid && bus.out_ready;
    assign w_last_word = (r_count == (r_nwords - c_one));

    // Subtract is A + ~B + 1, with the +1 supplied by the carry seeded at start.
    assign w_b_eff   = r_op_sub ? ~bus.b_word : bus.b_word;
    assign w_sum     = {1'b0, bus.a_word} + {1'b0, w_b_eff} + {{W{1'b0}}, r_carry};
    // Carry into the sign bit recovered from the sum bit and its two addend bits.
    assign w_msb_cin = w_sum[W-1] ^ bus.a_word[W-1] ^ w_b_eff[W-1];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded status outputs.
    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_out_fire && r_out_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Command latch plus carry chain, word counter and flag accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_sub   <= 1'b0;
            r_nwords   <= '0;
            r_count    <= '0;
            r_carry    <= 1'b0;
            r_zero_acc <= 1'b0;
            r_ovf_acc  <= 1'b0;
        end else if ((r_state == S_IDLE) && w_start_ok) begin
            r_op_sub   <= bus.op_sub;
            r_nwords   <= bus.nwords;
            r_count    <= '0;
            r_carry    <= bus.op_sub;
            r_zero_acc <= 1'b1;
            r_ovf_acc  <= 1'b0;
        end else if (w_in_fire) begin
            r_count    <= r_count + c_one;
            r_carry    <= w_sum[W];
            r_zero_acc <= r_zero_acc & (w_sum[W-1:0] == '0);
            if (w_last_word) begin
                r_ovf_acc <= w_msb_cin ^ w_sum[W];
            end
        end
    end

    // Single-stage result register; reloads back-to-back when drained and
    // refilled in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_word  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_in_fire) begin
            r_out_word  <= w_sum[W-1:0];
            r_out_valid <= 1'b1;
            r_out_last  <= w_last_word;
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end

    // Status flags load on entry to DONE and hold until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry_out <= 1'b0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if ((r_state == S_RUN) && (w_next == S_DONE)) begin
            r_carry_out <= r_carry;
            r_zero      <= r_zero_acc;
            r_ovf       <= r_ovf_acc;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_word  = r_out_word;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.carry_out = r_carry_out;
    assign bus.zero      = r_zero;
    assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mp_adc_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mp_adc_seq
// Description : Self-checking bench for mp_adc_seq. Full-width arithmetic
//               reference, per-cycle output checker and directed cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mp_adc_seq;

    localparam int W    = 32;
    localparam int MAXW = 8;
    localparam int NW_W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mp_adc_seq_if #(.W(W), .NW_W(NW_W)) bus ();

    mp_adc_seq #(.W(W), .MAXW(MAXW), .NW_W(NW_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference expectations (written by the driver, consumed by the checker)
    logic [W-1:0] exp_q[$];
    bit           exp_last_q[$];
    bit           exp_co, exp_z, exp_ov;
    int           ops_started = 0;
    int           cur_n       = 0;
    int           acc_cnt     = 0;

    // Checker-owned state
    int           ops_done     = 0;
    int           done_cnt     = 0;
    int           stall_cycles = 0;
    logic [W-1:0] cap_q[$];
    bit           cap_last_q[$];

    int or_mode = 0; // 0: always ready, 1: random, 2: one 3-cycle stall

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Full-width reference: treat the operands as n*W-bit integers.
    function automatic void model(input bit sub, input int n,
                                  input logic [255:0] a_in, input logic [255:0] b_in);
        logic [256:0] mask, a, b, bb, sum;
        bit sa, sb, sr;
        int wn;
        wn   = n * W;
        mask = (257'd1 << wn) - 257'd1;
        a    = {1'b0, a_in} & mask;
        b    = {1'b0, b_in} & mask;
        bb   = sub ? (~b & mask) : b;
        sum  = a + bb + 257'(sub);
        exp_co = sum[wn];
        exp_z  = ((sum & mask) == 257'd0);
        sa = a[wn-1];
        sb = b[wn-1];
        sr = sum[wn-1];
        exp_ov = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(sum[i*W +: W]);
            exp_last_q.push_back(i == n - 1);
        end
    endfunction

    function automatic logic [W-1:0] rword();
        logic [W-1:0] v;
        case ($urandom_range(0, 4))
            0:       v = '0;
            1:       v = '1;
            2:       v = 32'h8000_0000;
            3:       v = 32'h7FFF_FFFF;
            default: v = $urandom();
        endcase
        return v;
    endfunction

    // Result-side consumer readiness.
    initial begin
        int stall_left;
        bit fired;
        stall_left    = 0;
        fired         = 1'b0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                1: begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    fired = 1'b0;
                end
                2: begin
                    if (!fired && bus.out_valid) begin
                        fired      = 1'b1;
                        stall_left = 3;
                    end
                    if (stall_left > 0) begin
                        bus.out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        bus.out_ready = 1'b1;
                    end
                end
                default: begin
                    bus.out_ready = 1'b1;
                    fired = 1'b0;
                end
            endcase
        end
    end

    // Per-cycle checker, sampling on the falling edge.
    initial begin
        logic [W-1:0] prev_word;
        bit prev_stall, prev_last_hs, exp_done;
        bit held_co, held_z, held_ov;
        prev_word = '0; prev_stall = 0; prev_last_hs = 0;
        held_co = 0; held_z = 0; held_ov = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset in_ready",  bus.in_ready,  0);
                chk("reset out_valid", bus.out_valid, 0);
                chk("reset out_word",  bus.out_word,  0);
                chk("reset out_last",  bus.out_last,  0);
                chk("reset busy",      bus.busy,      0);
                chk("reset done",      bus.done,      0);
                chk("reset carry_out", bus.carry_out, 0);
                chk("reset zero",      bus.zero,      0);
                chk("reset ovf",       bus.ovf,       0);
                exp_q.delete();
                exp_last_q.delete();
                ops_done = ops_started;
                held_co = 0; held_z = 0; held_ov = 0;
                prev_stall = 0; prev_last_hs = 0;
            end else begin
                exp_done = prev_last_hs;
                chk("done pulse", bus.done, exp_done);
                if (exp_done) begin
                    chk("flag carry_out", bus.carry_out, exp_co);
                    chk("flag zero",      bus.zero,      exp_z);
                    chk("flag ovf",       bus.ovf,       exp_ov);
                    chk("words left at done", exp_q.size(), 0);
                    held_co = exp_co; held_z = exp_z; held_ov = exp_ov;
                    ops_done++;
                    done_cnt++;
                end else begin
                    chk("held carry_out", bus.carry_out, held_co);
                    chk("held zero",      bus.zero,      held_z);
                    chk("held ovf",       bus.ovf,       held_ov);
                end
                chk("busy", bus.busy, (ops_started != ops_done));

                if (ops_started == ops_done)
                    chk("in_ready while not running", bus.in_ready, 0);
                else if (acc_cnt >= cur_n)
                    chk("in_ready after all words", bus.in_ready, 0);
                if (bus.out_valid && !bus.out_ready) begin
                    chk("in_ready during stall", bus.in_ready, 0);
                    stall_cycles++;
                end

                if (prev_stall) begin
                    chk("stall out_valid", bus.out_valid, 1);
                    chk("stall out_word",  bus.out_word,  prev_word);
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_word  = bus.out_word;

                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra output word", exp_q.size(), 1);
                    end else begin
                        chk("out_word", bus.out_word, exp_q.pop_front());
                        chk("out_last", bus.out_last, exp_last_q.pop_front());
                    end
                    cap_q.push_back(bus.out_word);
                    cap_last_q.push_back(bus.out_last);
                    prev_last_hs = bus.out_last;
                end else begin
                    prev_last_hs = 0;
                end
            end
        end
    end

    // Issue one command and stream its operands. Entered at posedge+1 with
    // the sequencer idle. abort_after>0 pulses reset after that many words.
    task automatic run_op(input bit sub, input int n,
                          input logic [255:0] a, input logic [255:0] b,
                          input int abort_after, input bit noise, input bit extra);
        bit valid_cmd, fire, got_done;
        int i, guard;
        valid_cmd = (n >= 1) && (n <= MAXW);
        bus.start    = 1'b1;
        bus.op_sub   = sub;
        bus.nwords   = NW_W'(n);
        bus.in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.a_word   = $urandom();
        bus.b_word   = $urandom();
        if (valid_cmd) model(sub, n, a, b);
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        if (!valid_cmd) begin
            repeat (3) @(posedge clk);
            #1;
            return;
        end
        acc_cnt = 0;
        cur_n   = n;
        ops_started++;
        i = 0;
        guard = 0;
        while (i < n && guard < 500) begin
            if (noise && ($urandom_range(0, 3) == 0)) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.a_word   = a[i*W +: W];
                bus.b_word   = b[i*W +: W];
            end
            if (noise) begin
                bus.start  = ($urandom_range(0, 5) == 0);
                bus.nwords = NW_W'($urandom_range(0, 15));
                bus.op_sub = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            fire = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (fire) begin
                i++;
                acc_cnt++;
                if (abort_after != 0 && i == abort_after) begin
                    rst_n = 1'b0;
                    #1;
                    chk("abort out_valid", bus.out_valid, 0);
                    chk("abort out_word",  bus.out_word,  0);
                    chk("abort busy",      bus.busy,      0);
                    chk("abort in_ready",  bus.in_ready,  0);
                    bus.start    = 1'b0;
                    bus.in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                    rst_n = 1'b1;
                    return;
                end
            end
            guard++;
        end
        chk("input words accepted", i, n);
        bus.start    = 1'b0;
        bus.in_valid = extra;
        bus.a_word   = $urandom();
        bus.b_word   = $urandom();
        got_done = 1'b0;
        for (int k = 0; k < 300 && !got_done; k++) begin
            @(negedge clk);
            if (bus.done) got_done = 1'b1;
        end
        chk("done timeout", got_done, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Main stimulus.
    initial begin
        int base, d0;
        logic [255:0] a, b;
        bus.start = 0; bus.op_sub = 0; bus.nwords = '0;
        bus.in_valid = 0; bus.a_word = '0; bus.b_word = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("por out_valid", bus.out_valid, 0);
        chk("por busy",      bus.busy,      0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Add, 2 words: 0x00000000_FFFFFFFF + 1
        base = cap_q.size();
        run_op(0, 2, 256'h0000_0000_FFFF_FFFF, 256'h1, 0, 0, 0);
        chk("t1 word0", cap_q[base],        32'h0000_0000);
        chk("t1 word1", cap_q[base+1],      32'h0000_0001);
        chk("t1 last0", cap_last_q[base],   0);
        chk("t1 last1", cap_last_q[base+1], 1);
        chk("t1 carry", bus.carry_out, 0);
        chk("t1 zero",  bus.zero,      0);
        chk("t1 ovf",   bus.ovf,       0);

        // Subtract, 1 word: 5 - 5
        base = cap_q.size();
        run_op(1, 1, 256'd5, 256'd5, 0, 0, 0);
        chk("t2 word0", cap_q[base],      32'h0);
        chk("t2 last0", cap_last_q[base], 1);
        chk("t2 carry", bus.carry_out, 1);
        chk("t2 zero",  bus.zero,      1);
        chk("t2 ovf",   bus.ovf,       0);

        // Subtract, 2 words: 0 - 1
        base = cap_q.size();
        run_op(1, 2, 256'd0, 256'd1, 0, 0, 0);
        chk("t3 word0", cap_q[base],   32'hFFFF_FFFF);
        chk("t3 word1", cap_q[base+1], 32'hFFFF_FFFF);
        chk("t3 carry", bus.carry_out, 0);
        chk("t3 zero",  bus.zero,      0);
        chk("t3 ovf",   bus.ovf,       0);

        // Add, 1 word: signed overflow; then an illegal zero-length start
        base = cap_q.size();
        run_op(0, 1, 256'h7FFF_FFFF, 256'h1, 0, 0, 0);
        chk("t4 word0", cap_q[base], 32'h8000_0000);
        chk("t4 ovf",   bus.ovf,       1);
        chk("t4 carry", bus.carry_out, 0);
        d0 = done_cnt;
        run_op(0, 0, 256'h1, 256'h1, 0, 0, 0);
        chk("t4 nwords=0 no done", done_cnt, d0);
        chk("t4 nwords=0 busy",    bus.busy, 0);
        chk("t4 nwords=0 ovf",     bus.ovf,  1);

        // Backpressure: 4 words, in_valid held, 3-cycle stall after first result
        or_mode = 2;
        d0 = stall_cycles;
        base = cap_q.size();
        a = {128'h0, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        run_op(0, 4, a, 256'h1, 0, 0, 1);
        or_mode = 0;
        chk("t5 stall cycles", stall_cycles - d0, 3);
        chk("t5 word count", cap_q.size() - base, 4);
        chk("t5 word0", cap_q[base],   32'h0);
        chk("t5 word1", cap_q[base+1], 32'h0);
        chk("t5 word2", cap_q[base+2], 32'h0);
        chk("t5 word3", cap_q[base+3], 32'h2);
        chk("t5 carry", bus.carry_out, 0);

        // Reset mid-operation after word 2 of 4, then a fresh 1 + 1
        d0 = done_cnt;
        run_op(0, 4, {4{64'h1234_5678_FFFF_FFFF}}, {4{64'h1}}, 2, 0, 0);
        chk("t6 no done on abort", done_cnt, d0);
        base = cap_q.size();
        run_op(0, 1, 256'd1, 256'd1, 0, 0, 0);
        chk("t6 word0", cap_q[base], 32'h2);
        chk("t6 done count", done_cnt, d0 + 1);

        // Randomized commands with random backpressure and start noise
        or_mode = 1;
        for (int t = 0; t < 40; t++) begin
            int n;
            if ($urandom_range(0, 9) == 0)
                n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAXW + 1, 15);
            else
                n = $urandom_range(1, MAXW);
            for (int k = 0; k < MAXW; k++) begin
                a[k*W +: W] = rword();
                b[k*W +: W] = rword();
            end
            run_op(1'($urandom_range(0, 1)), n, a, b, 0, 1, 1'($urandom_range(0, 1)));
        end
        or_mode = 0;
        repeat (3) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
